// File: rtl/mem_burst_master.sv
// mem_burst_master: sequences 32-bit word requests as byte bursts on the exmemory port.
// Reads are assembled little-endian and returned with a one-cycle rsp_valid pulse.
module mem_burst_master #(
    parameter int AW     = 8,
    parameter int BEATS  = 4,
    parameter int RD_LAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [AW-1:0]     req_addr,
    input  logic [8*BEATS-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [8*BEATS-1:0] rsp_rdata,
    output logic              busy,
    output logic [AW-1:0]     mem_adr,
    output logic              mem_memwrite,
    output logic [7:0]        mem_writedata,
    input  logic [7:0]        mem_memdata
);
    localparam int W  = 8 * BEATS;
    localparam int CW = $clog2(BEATS + RD_LAT + 1);
    localparam logic [CW-1:0] ADR_END = CW'(BEATS - 1);
    localparam logic [CW-1:0] RD_END  = CW'(BEATS - 1 + RD_LAT);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-9:0]   wd_q;
    logic [W-9:0]   rd_q;
    logic           req_ready_q, rsp_valid_q, busy_q, memwrite_q;
    logic [W-1:0]   rsp_rdata_q;
    logic [AW-1:0]  adr_q;
    logic [7:0]     writedata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wd_q        <= '0;
            rd_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            memwrite_q  <= 1'b0;
            rsp_rdata_q <= '0;
            adr_q       <= '0;
            writedata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    state_q     <= req_write ? WRITE : READ;
                    req_ready_q <= 1'b0;
                    busy_q      <= 1'b1;
                    cnt_q       <= '0;
                    adr_q       <= req_addr;
                    memwrite_q  <= req_write;
                    writedata_q <= req_write ? req_wdata[7:0] : writedata_q;
                    wd_q        <= req_wdata[W-1:8];
                end
                WRITE: if (cnt_q == ADR_END) begin
                    state_q     <= RESP;
                    memwrite_q  <= 1'b0;
                    rsp_valid_q <= 1'b1;
                end else begin
                    cnt_q       <= cnt_q + CW'(1);
                    adr_q       <= adr_q + AW'(1);
                    writedata_q <= wd_q[7:0];
                    wd_q        <= wd_q >> 8;
                end
                // Shift every cycle; only the last BEATS captures survive to RESP.
                READ, DRAIN: begin
                    rd_q <= {mem_memdata, rd_q[W-9:8]};
                    if (cnt_q == RD_END) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= {mem_memdata, rd_q};
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        adr_q   <= (cnt_q < ADR_END) ? adr_q + AW'(1) : adr_q;
                        state_q <= (cnt_q < ADR_END) ? READ : DRAIN;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign busy          = busy_q;
    assign mem_adr       = adr_q;
    assign mem_memwrite  = memwrite_q;
    assign mem_writedata = writedata_q;
endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: checks burst sequencing, read assembly and reset behaviour
// against a byte-array memory model and a word-level reference memory.
module tb_mem_burst_master;
    logic        clk = 1'b0;
    logic        reset, req_valid, req_write, req_ready, rsp_valid, busy, mem_memwrite;
    logic [7:0]  req_addr, mem_adr, mem_writedata, mem_memdata;
    logic [31:0] req_wdata, rsp_rdata;
    logic        req_valid2, req_ready2, rsp_valid2, busy2, mem_memwrite2;
    logic [7:0]  req_addr2, mem_adr2, mem_writedata2, mem_memdata2;
    logic [31:0] rsp_rdata2;

    logic [7:0]  mem [256];
    logic [7:0]  mem2 [256];
    logic [7:0]  ref_mem [256];
    logic [31:0] last_rd;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    mem_burst_master dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .mem_adr(mem_adr), .mem_memwrite(mem_memwrite),
        .mem_writedata(mem_writedata), .mem_memdata(mem_memdata)
    );

    mem_burst_master #(.RD_LAT(1)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_write(1'b0), .req_addr(req_addr2), .req_wdata(32'h0),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
        .mem_adr(mem_adr2), .mem_memwrite(mem_memwrite2),
        .mem_writedata(mem_writedata2), .mem_memdata(mem_memdata2)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    assign mem_memdata = mem[mem_adr];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = pat(i);
        forever begin
            @(posedge clk);
            if (mem_memwrite) mem[mem_adr] <= mem_writedata;
        end
    end

    // One-cycle registered read port for the RD_LAT=1 instance.
    initial begin
        for (int i = 0; i < 256; i++) mem2[i] = pat(i);
        mem_memdata2 = 8'h00;
        forever begin
            @(posedge clk);
            mem_memdata2 <= mem2[mem_adr2];
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[8'(a + k)];
        return w;
    endfunction

    // Called just after a rising edge with the DUT idle; returns with the DUT idle again.
    task automatic txn(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                       output logic [31:0] rd);
        logic [31:0] exp;
        exp = model_word(a);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        @(negedge clk);
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~wr; req_addr = 8'($urandom); req_wdata = $urandom;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("beat_adr", {24'b0, mem_adr}, {24'b0, 8'(a + k)});
            chk("beat_memwrite", {31'b0, mem_memwrite}, {31'b0, wr});
            if (wr) chk("beat_wdata", {24'b0, mem_writedata}, {24'b0, wd[8*k +: 8]});
            chk("beat_flags", {29'b0, busy, req_ready, rsp_valid}, 32'b100);
        end
        @(negedge clk);
        chk("resp_flags", {28'b0, busy, req_ready, rsp_valid, mem_memwrite}, 32'b1010);
        if (wr) begin
            chk("rdata_hold", rsp_rdata, last_rd);
            for (int k = 0; k < 4; k++) ref_mem[8'(a + k)] = wd[8*k +: 8];
        end else begin
            chk("rdata", rsp_rdata, exp);
            last_rd = exp;
        end
        rd = rsp_rdata;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        tbl [7];
        logic [31:0] rd;
        int          nbad;
        tbl[0] = '{1'b1, 8'h10, 32'hDDCCBBAA, 32'h0};
        tbl[1] = '{1'b0, 8'h10, 32'h0,        32'hDDCCBBAA};
        tbl[2] = '{1'b1, 8'hFE, 32'h44332211, 32'h0};
        tbl[3] = '{1'b0, 8'hFE, 32'h0,        32'h44332211};
        tbl[4] = '{1'b0, 8'hFF, 32'h0,        32'h58443322};
        tbl[5] = '{1'b1, 8'h10, 32'h12345678, 32'h0};
        tbl[6] = '{1'b0, 8'h12, 32'h0,        32'h4F4E1234};
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        last_rd = 32'h0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h0; req_wdata = 32'h0;
        req_valid2 = 1'b0; req_addr2 = 8'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", {28'b0, req_ready, rsp_valid, mem_memwrite, busy}, 32'b1000);
        chk("reset_adr", {24'b0, mem_adr}, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // RD_LAT=1: response one cycle later, last address held through the drain cycle.
        req_valid2 = 1'b1; req_addr2 = 8'h10;
        @(posedge clk); #1;
        req_valid2 = 1'b0; req_addr2 = 8'h77;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("lat1_adr", {24'b0, mem_adr2}, {24'b0, 8'h10 + 8'(c < 5 ? c - 1 : 3)});
            chk("lat1_rsp", {30'b0, rsp_valid2, mem_memwrite2}, {30'b0, c == 6, 1'b0});
            if (c == 6) chk("lat1_rdata", rsp_rdata2, {pat(8'h13), pat(8'h12), pat(8'h11), pat(8'h10)});
            @(posedge clk); #1;
        end

        for (int i = 0; i < 7; i++) begin
            txn(tbl[i].wr, tbl[i].a, tbl[i].wd, rd);
            if (!tbl[i].wr) chk("tbl_rdata", rd, tbl[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom), 8'($urandom), $urandom, rd);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        // Request held through a busy read with a moving address.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30;
        @(posedge clk); #1;
        for (int c = 1; c <= 6; c++) begin
            req_addr = 8'h40 + 8'(c);
            @(negedge clk);
            chk("held_ready", {31'b0, req_ready}, {31'b0, c == 6});
            if (c == 5) chk("held_first_rdata", rsp_rdata, model_word(8'h30));
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("held_second_adr", {24'b0, mem_adr}, {24'b0, 8'h46 + 8'(k)});
        end
        @(negedge clk);
        chk("held_second_rsp", {31'b0, rsp_valid}, 32'd1);
        chk("held_second_rdata", rsp_rdata, model_word(8'h46));
        last_rd = model_word(8'h46);
        @(posedge clk); #1;

        // Reset lands on the edge that would start write cycle 3, with a request pending.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 32'h88776655;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b1; req_addr = 8'h80;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_flags", {28'b0, req_ready, rsp_valid, mem_memwrite, busy}, 32'b1000);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rst_mid_quiet", {30'b0, rsp_valid, mem_memwrite}, 32'b0);
        end
        chk("rst_mid_mem20", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]},
            {pat(8'h23), pat(8'h22), 8'h66, 8'h55});
        chk("rst_prio_mem80", {24'b0, mem[8'h80]}, {24'b0, pat(8'h80)});
        ref_mem[8'h20] = 8'h55; ref_mem[8'h21] = 8'h66;

        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
        chk("final_mem", nbad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
